// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity mode codes and baud divisor helper.
// Used by the transmitter and by the matching receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-time counter: tick is high in the last clock of each bit period; clear restarts the period.
// Latency: tick is a combinational decode of the counter; no backpressure.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic Clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (reset || clear) cnt <= '0;
    else                cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == CW'(CLKS_PER_BIT - 1));

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter (data bits, parity, stop bits, divisor); UART_TX_BREAK_EN adds line break.
// Latency: Serial drops to the start bit on the accepting edge; tx_done marks the last stop-bit cycle.
// Backpressure: tx_ready is low for the whole frame (and during break/guard time); tx_data is latched on accept.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 Clk,
  input  logic                 reset,
`ifdef UART_TX_BREAK_EN
  input  logic                 tx_break,
`endif
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 Serial,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_divisor
    $fatal(1, "uart_tx_param: CLKS_PER_BIT must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $fatal(1, "uart_tx_param: DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $fatal(1, "uart_tx_param: PARITY_MODE must be 0..2");
  end

  state_t               state, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_idx;
  logic                 par_q, serial_d, tick, cnt_clr, accept, idle_hold;

`ifdef UART_TX_BREAK_EN
  logic brk_hold, brk_pend, brk_req;
  assign brk_req   = tx_break || brk_pend;
  assign idle_hold = brk_hold;
  assign tx_ready  = (state == IDLE) && !reset && !brk_hold && !brk_req;
`else
  assign idle_hold = 1'b0;
  assign tx_ready  = (state == IDLE) && !reset;
`endif

  assign accept  = tx_valid && tx_ready;
  assign tx_done = !reset && (state == STOP) && tick && (bit_idx == LAST_STOP);
  // Counter sits at zero in IDLE so the first bit period starts exactly at acceptance.
  assign cnt_clr = tick || (state == BREAK) || ((state == IDLE) && !idle_hold);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .Clk  (Clk),
    .reset(reset),
    .clear(cnt_clr),
    .tick (tick)
  );

  always_comb begin
    state_d  = state;
    shift_d  = shift_q;
    serial_d = 1'b1;
    case (state)
      IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (brk_req) state_d = BREAK;
        else
`endif
        if (accept) state_d = START;
      end
      START:  if (tick) state_d = DATA;
      DATA:   if (tick && bit_idx == LAST_DATA)
                state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick && bit_idx == LAST_STOP) state_d = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK:  if (!tx_break) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase

    if (accept)                     shift_d = tx_data;
    else if (state == DATA && tick) shift_d = shift_q >> 1;

    case (state_d)
      START, BREAK: serial_d = 1'b0;
      DATA:         serial_d = shift_d[0];
      PARITY:       serial_d = par_q;
      default:      serial_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_idx <= '0;
      par_q   <= 1'b0;
      Serial  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_d;
      shift_q <= shift_d;
      Serial  <= serial_d;
      busy    <= (state_d != IDLE);
      if (state_d != state) bit_idx <= '0;
      else if (tick)        bit_idx <= bit_idx + 4'd1;
      // The word is still unshifted throughout START, so parity comes from the latched copy.
      if (state == START)
        par_q <= (PARITY_MODE == PARITY_ODD) ? ~^shift_q : ^shift_q;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge Clk) begin
    if (reset) begin
      brk_hold <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      if (state == BREAK && state_d == IDLE) brk_hold <= 1'b1;
      else if (state == IDLE && tick)        brk_hold <= 1'b0;
      if (state_d == BREAK)                  brk_pend <= 1'b0;
      else if (tx_break && state != IDLE)    brk_pend <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1, 7E2, 8O1) at 10 clocks per bit against a frame-level line model.
// Break scenarios are included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_param;

  logic       Clk = 1'b0;
  logic       reset;
  logic [2:0] vld, rdy, ser, bsy, done;
  logic [2:0] brk;
  logic [8:0] dat [3];

  int DB [3] = '{8, 7, 8};
  int PM [3] = '{0, 1, 2};
  int SB [3] = '{1, 2, 1};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u0 (
    .Clk(Clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk[0]),
`endif
    .tx_valid(vld[0]), .tx_data(dat[0][7:0]), .tx_ready(rdy[0]), .Serial(ser[0]), .busy(bsy[0]), .tx_done(done[0]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
    .Clk(Clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk[1]),
`endif
    .tx_valid(vld[1]), .tx_data(dat[1][6:0]), .tx_ready(rdy[1]), .Serial(ser[1]), .busy(bsy[1]), .tx_done(done[1]));

  uart_tx_param #(.CLK_FREQ(1000), .BAUD_RATE(100), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u2 (
    .Clk(Clk), .reset(reset),
`ifdef UART_TX_BREAK_EN
    .tx_break(brk[2]),
`endif
    .tx_valid(vld[2]), .tx_data(dat[2][7:0]), .tx_ready(rdy[2]), .Serial(ser[2]), .busy(bsy[2]), .tx_done(done[2]));

  // Reference model: the frame is a list of line symbols, each one bit time long.
  function automatic int frame_bits(input int u);
    return 1 + DB[u] + ((PM[u] != 0) ? 1 : 0) + SB[u];
  endfunction

  function automatic logic line_bit(input int u, input logic [8:0] w, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= DB[u]) return w[k-1];
    if (PM[u] != 0 && k == DB[u] + 1) begin
      ones = 0;
      for (int i = 0; i < DB[u]; i++) ones += int'(w[i]);
      return (PM[u] == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
    end
    return 1'b1;
  endfunction

  // Entered and left on a falling edge; leaves in the idle cycle after the frame.
  task automatic check_frame(input int u, input logic [8:0] w, input bit hold, input bit scramble, input int brk_at);
    int   n;
    int   len;
    logic exp_s;
    logic exp_r;
    n = 0;
    while (!rdy[u] && n < 300) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    if (rdy[u] !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_wait u%0d: tx_ready=%b required 1", u, rdy[u]);
    end
    vld[u] = 1'b1;
    dat[u] = w;
    len = frame_bits(u) * 10;
    @(posedge Clk);
    for (int c = 1; c <= len; c++) begin
      @(negedge Clk);
      if (c == 1 && !hold) vld[u] = 1'b0;
      exp_s = line_bit(u, w, (c - 1) / 10);
      n_cmp++;
      if (ser[u] !== exp_s || bsy[u] !== 1'b1 || rdy[u] !== 1'b0 || done[u] !== (c == len)) begin
        n_bad++;
        $display("FAIL frame u%0d w=%h c=%0d: serial=%b busy=%b ready=%b done=%b required %b 1 0 %b",
                 u, w, c, ser[u], bsy[u], rdy[u], done[u], exp_s, (c == len));
      end
      if (scramble) dat[u] = 9'($urandom);
      if (c == brk_at) begin
`ifdef UART_TX_BREAK_EN
        brk[u] = 1'b1;
`endif
      end
    end
    @(negedge Clk);
    exp_r = (brk_at == 0);
    n_cmp++;
    if (ser[u] !== 1'b1 || bsy[u] !== 1'b0 || done[u] !== 1'b0 || rdy[u] !== exp_r) begin
      n_bad++;
      $display("FAIL idle_after u%0d: serial=%b busy=%b done=%b ready=%b required 1 0 0 %b",
               u, ser[u], bsy[u], done[u], rdy[u], exp_r);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    vld   = '0;
    brk   = '0;
    for (int u = 0; u < 3; u++) dat[u] = '0;
    repeat (3) @(negedge Clk);
    for (int u = 0; u < 3; u++) begin
      n_cmp++;
      if (ser[u] !== 1'b1 || bsy[u] !== 1'b0 || done[u] !== 1'b0 || rdy[u] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state u%0d: serial=%b busy=%b done=%b ready=%b required 1 0 0 0",
                 u, ser[u], bsy[u], done[u], rdy[u]);
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (rdy !== 3'b111) begin
      n_bad++;
      $display("FAIL ready_after_reset: tx_ready=%b required 111", rdy);
    end
    @(negedge Clk);
  endtask

  task automatic test_8n1;
    check_frame(0, 9'h0A5, 1'b0, 1'b0, 0);
    repeat (4) check_frame(0, 9'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_7e2;
    check_frame(1, 9'h013, 1'b0, 1'b0, 0);
    repeat (3) check_frame(1, 9'($urandom_range(0, 127)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_8o1;
    check_frame(2, 9'h0FF, 1'b0, 1'b0, 0);
    repeat (3) check_frame(2, 9'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back;
    check_frame(0, 9'h055, 1'b1, 1'b0, 0);
    check_frame(0, 9'h00F, 1'b0, 1'b0, 0);
    check_frame(1, 9'($urandom_range(0, 127)), 1'b1, 1'b0, 0);
    check_frame(1, 9'($urandom_range(0, 127)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_reset_mid_frame;
    logic [8:0] w;
    logic       exp_s;
    w = 9'h03C;
    vld[0] = 1'b1;
    dat[0] = w;
    @(posedge Clk);
    for (int c = 1; c <= 44; c++) begin
      @(negedge Clk);
      if (c == 1) vld[0] = 1'b0;
      exp_s = line_bit(0, w, (c - 1) / 10);
      n_cmp++;
      if (ser[0] !== exp_s) begin
        n_bad++;
        $display("FAIL pre_reset c=%0d: serial=%b required %b", c, ser[0], exp_s);
      end
    end
    @(negedge Clk);
    reset = 1'b1;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b0 || done[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_cycle: ready=%b done=%b required 0 0", rdy[0], done[0]);
    end
    @(negedge Clk);
    n_cmp++;
    if (ser[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_edge: serial=%b busy=%b ready=%b required 1 0 0", ser[0], bsy[0], rdy[0]);
    end
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      n_cmp++;
      if (done[0] !== 1'b0 || ser[0] !== 1'b1 || rdy[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL aborted_quiet c=%0d: done=%b serial=%b ready=%b required 0 1 1", c, done[0], ser[0], rdy[0]);
      end
      @(negedge Clk);
    end
    check_frame(0, 9'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
  endtask

  task automatic test_data_stability;
    check_frame(0, 9'h081, 1'b0, 1'b1, 0);
    check_frame(1, 9'($urandom_range(0, 127)), 1'b0, 1'b1, 0);
    check_frame(2, 9'($urandom_range(0, 255)), 1'b0, 1'b1, 0);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break;
    int n;
    brk[0] = 1'b1;
    #1;
    n_cmp++;
    if (rdy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL break_ready_gate: ready=%b required 0", rdy[0]);
    end
    for (int c = 1; c <= 45; c++) begin
      @(negedge Clk);
      if (c == 35) begin
        n_cmp++;
        if (ser[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL break_line c=%0d: serial=%b required 0", c, ser[0]);
        end
        brk[0] = 1'b0;
      end else begin
        n_cmp++;
        if (ser[0] !== (c > 35) || rdy[0] !== 1'b0 || done[0] !== 1'b0) begin
          n_bad++;
          $display("FAIL break c=%0d: serial=%b ready=%b done=%b required %b 0 0", c, ser[0], rdy[0], done[0], (c > 35));
        end
      end
    end
    n = 0;
    while (!rdy[0] && n < 40) begin
      @(negedge Clk);
      n++;
    end
    n_cmp++;
    if (rdy[0] !== 1'b1 || ser[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL break_release: ready=%b serial=%b required 1 1", rdy[0], ser[0]);
    end
  endtask

  task automatic test_break_mid_frame;
    int n;
    check_frame(0, 9'($urandom_range(0, 255)), 1'b0, 1'b0, 30);
    for (int c = 1; c <= 8; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (ser[0] !== 1'b0 || rdy[0] !== 1'b0 || done[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL break_after_frame c=%0d: serial=%b ready=%b done=%b required 0 0 0", c, ser[0], rdy[0], done[0]);
      end
    end
    brk[0] = 1'b0;
    n = 0;
    while (!rdy[0] && n < 40) begin
      @(negedge Clk);
      n++;
      n_cmp++;
      if (ser[0] !== 1'b1 && n > 1) begin
        n_bad++;
        $display("FAIL break_guard n=%0d: serial=%b required 1", n, ser[0]);
      end
    end
    n_cmp++;
    if (rdy[0] !== 1'b1 || n < 10) begin
      n_bad++;
      $display("FAIL break_guard_len: ready=%b cycles=%0d required 1 and at least 10", rdy[0], n);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_8o1();
    test_back_to_back();
    test_reset_mid_frame();
    test_data_stability();
`ifdef UART_TX_BREAK_EN
    test_break();
    test_break_mid_frame();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
